// File: rtl/ccx_pkg.sv
// Shared types and sizing for the CCX accelerator: operation codes, FSM states
// and the chunk/operand geometry of the serial link.
package ccx_pkg;

    localparam int CCX_CHUNKSIZE = 4;
    localparam int CCX_XLEN      = 32;
    localparam int CCX_NCHUNKS   = CCX_XLEN / CCX_CHUNKSIZE;
    localparam int CCX_CW        = $clog2(CCX_NCHUNKS);
    localparam int CCX_SHW       = $clog2(CCX_XLEN);

    typedef enum logic [1:0] {
        CCX_ROL  = 2'd0,
        CCX_POPC = 2'd1,
        CCX_REV8 = 2'd2,
        CCX_MAXU = 2'd3
    } ccx_op_e;

    typedef enum logic [1:0] {
        CCX_ST_IDLE = 2'd0,
        CCX_ST_RECV = 2'd1,
        CCX_ST_EXEC = 2'd2,
        CCX_ST_SEND = 2'd3
    } ccx_state_e;

endpackage

// File: rtl/ccx_if.sv
// Chunk-serial CCX link: the SoC side (master) streams operands, the
// accelerator (slave) streams the result back.
interface ccx_if;
    import ccx_pkg::*;

    logic [CCX_CHUNKSIZE-1:0] ccx_rs_a;
    logic [CCX_CHUNKSIZE-1:0] ccx_rs_b;
    logic [1:0]               ccx_sel;
    logic                     ccx_req;
    logic [CCX_CHUNKSIZE-1:0] ccx_res;
    logic                     ccx_resp;

    modport master (
        output ccx_rs_a, ccx_rs_b, ccx_sel, ccx_req,
        input  ccx_res, ccx_resp
    );

    modport slave (
        input  ccx_rs_a, ccx_rs_b, ccx_sel, ccx_req,
        output ccx_res, ccx_resp
    );

endinterface

// File: rtl/ccx_alu.sv
// Combinational datapath for the four CCX operations; the top registers the
// result during its single execute cycle.
module ccx_alu
    import ccx_pkg::*;
(
    input  ccx_op_e              op,
    input  logic [CCX_XLEN-1:0]  a,
    input  logic [CCX_XLEN-1:0]  b,
    output logic [CCX_XLEN-1:0]  result
);

    logic [2*CCX_XLEN-1:0] rot_s;
    logic [CCX_XLEN-1:0]   popc_s;
    logic [CCX_XLEN-1:0]   rev_s;

    // Compute every candidate result, then select by op.
    always_comb begin
        // Upper half of the doubled word shifted left is the left rotation.
        rot_s  = {a, a} << b[CCX_SHW-1:0];
        popc_s = '0;
        rev_s  = '0;
        for (int i = 0; i < CCX_XLEN; i++) begin
            popc_s = popc_s + {{(CCX_XLEN-1){1'b0}}, a[i]};
        end
        for (int i = 0; i < CCX_XLEN / 8; i++) begin
            rev_s[i*8 +: 8] = a[(CCX_XLEN/8-1-i)*8 +: 8];
        end
        case (op)
            CCX_ROL:  result = rot_s[2*CCX_XLEN-1:CCX_XLEN];
            CCX_POPC: result = popc_s;
            CCX_REV8: result = rev_s;
            CCX_MAXU: result = (a >= b) ? a : b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/ccx_accel.sv
// CCX accelerator top: deserialises two operands, runs one ALU operation and
// serialises the result, LSB chunk first, with registered outputs.
module ccx_accel
    import ccx_pkg::*;
(
    input  logic   clk_i,
    input  logic   rst_in,
    ccx_if.slave   ccx
);

    localparam logic [CCX_CW-1:0] LAST_CHUNK = CCX_CW'(CCX_NCHUNKS - 1);

    ccx_state_e                state_r;
    logic [CCX_CW-1:0]         cnt_r;
    ccx_op_e                   op_r;
    logic [CCX_XLEN-1:0]       a_r;
    logic [CCX_XLEN-1:0]       b_r;
    logic [CCX_XLEN-1:0]       acc_r;
    logic [CCX_CHUNKSIZE-1:0]  res_r;
    logic                      resp_r;
    logic [CCX_XLEN-1:0]       alu_res_s;

    ccx_alu u_alu (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .result (alu_res_s)
    );

    // Transaction FSM with operand load, execute capture and result shift-out.
    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state_r <= CCX_ST_IDLE;
            cnt_r   <= '0;
            op_r    <= CCX_ROL;
            a_r     <= '0;
            b_r     <= '0;
            acc_r   <= '0;
            res_r   <= '0;
            resp_r  <= 1'b0;
        end else begin
            case (state_r)
                CCX_ST_IDLE: begin
                    if (ccx.ccx_req) begin
                        a_r     <= {{(CCX_XLEN-CCX_CHUNKSIZE){1'b0}}, ccx.ccx_rs_a};
                        b_r     <= {{(CCX_XLEN-CCX_CHUNKSIZE){1'b0}}, ccx.ccx_rs_b};
                        op_r    <= ccx_op_e'(ccx.ccx_sel);
                        cnt_r   <= CCX_CW'(1);
                        state_r <= CCX_ST_RECV;
                    end
                end
                CCX_ST_RECV: begin
                    if (ccx.ccx_req) begin
                        a_r[cnt_r*CCX_CHUNKSIZE +: CCX_CHUNKSIZE] <= ccx.ccx_rs_a;
                        b_r[cnt_r*CCX_CHUNKSIZE +: CCX_CHUNKSIZE] <= ccx.ccx_rs_b;
                        if (cnt_r == LAST_CHUNK) begin
                            cnt_r   <= '0;
                            state_r <= CCX_ST_EXEC;
                        end else begin
                            cnt_r <= cnt_r + CCX_CW'(1);
                        end
                    end else begin
                        // A gap in req aborts: drop the partial operands silently.
                        a_r     <= '0;
                        b_r     <= '0;
                        cnt_r   <= '0;
                        state_r <= CCX_ST_IDLE;
                    end
                end
                CCX_ST_EXEC: begin
                    res_r   <= alu_res_s[CCX_CHUNKSIZE-1:0];
                    acc_r   <= alu_res_s >> CCX_CHUNKSIZE;
                    resp_r  <= 1'b1;
                    cnt_r   <= '0;
                    state_r <= CCX_ST_SEND;
                end
                CCX_ST_SEND: begin
                    // cnt_r indexes the chunk currently on the output pins.
                    if (cnt_r == LAST_CHUNK) begin
                        res_r   <= '0;
                        resp_r  <= 1'b0;
                        acc_r   <= '0;
                        cnt_r   <= '0;
                        state_r <= CCX_ST_IDLE;
                    end else begin
                        res_r <= acc_r[CCX_CHUNKSIZE-1:0];
                        acc_r <= acc_r >> CCX_CHUNKSIZE;
                        cnt_r <= cnt_r + CCX_CW'(1);
                    end
                end
                default: begin
                    res_r   <= '0;
                    resp_r  <= 1'b0;
                    cnt_r   <= '0;
                    state_r <= CCX_ST_IDLE;
                end
            endcase
        end
    end

    assign ccx.ccx_res  = res_r;
    assign ccx.ccx_resp = resp_r;

endmodule

// File: tb/tb_ccx_accel.sv
// Scoreboard bench for ccx_accel: a driver streams directed and random
// transactions, a negedge monitor reassembles result words and checks them.
module tb_ccx_accel;

    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    typedef struct {
        logic [31:0] res;
        int          start;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    ccx_if bus ();

    ccx_accel dut (
        .clk_i  (clk),
        .rst_in (rst_n),
        .ccx    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_model(input logic [1:0] sel,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [31:0] r;
        case (sel)
            2'd0: begin
                r = a;
                for (int i = 0; i < int'(b % 32); i++) r = {r[30:0], r[31]};
            end
            2'd1: r = 32'($countones(a));
            2'd2: begin
                for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*(3-i) +: 8];
            end
            default: r = (a >= b) ? a : b;
        endcase
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    // Eight operand chunks with sel disturbed after chunk 0; expectation queued.
    task automatic send_chunks(input logic [1:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input string nm);
        exp_t e;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            bus.ccx_req  = 1'b1;
            bus.ccx_rs_a = a[k*4 +: 4];
            bus.ccx_rs_b = b[k*4 +: 4];
            bus.ccx_sel  = (k == 0) ? sel : 2'($urandom);
        end
        e.res   = ref_model(sel, a, b);
        e.start = cyc + 2;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    // The nine cycles in which req is ignored (EXEC plus SEND); drive noise.
    task automatic ignored_window();
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            bus.ccx_req  = 1'($urandom);
            bus.ccx_rs_a = 4'($urandom);
            bus.ccx_rs_b = 4'($urandom);
            bus.ccx_sel  = 2'($urandom);
        end
    endtask

    task automatic txn(input logic [1:0] sel, input logic [31:0] a,
                       input logic [31:0] b, input string nm);
        send_chunks(sel, a, b, nm);
        ignored_window();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            bus.ccx_req  = 1'b0;
            bus.ccx_rs_a = 4'($urandom);
            bus.ccx_rs_b = 4'($urandom);
            bus.ccx_sel  = 2'($urandom);
        end
    endtask

    // Monitor: reassembles result words and checks framing and latency.
    initial begin
        int          n;
        logic [31:0] word;
        n = 0;
        word = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("reset_resp", 32'(bus.ccx_resp), 32'd0);
                check("reset_res", 32'(bus.ccx_res), 32'd0);
                n = 0;
            end else if (bus.ccx_resp) begin
                if (n == 0 && exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_resp: got resp=1 res=%h required resp=0 (cyc %0d)",
                             bus.ccx_res, cyc);
                end else begin
                    if (n == 0) check({exp_q[0].name, "_latency"}, 32'(cyc), 32'(exp_q[0].start));
                    word[n*4 +: 4] = bus.ccx_res;
                    n++;
                    if (n == 8) begin
                        check(exp_q[0].name, word, exp_q[0].res);
                        void'(exp_q.pop_front());
                        n = 0;
                    end
                end
            end else begin
                check("idle_res_zero", 32'(bus.ccx_res), 32'd0);
                if (n != 0) begin
                    tests++;
                    fails++;
                    $display("FAIL resp_dropped: got %0d chunks required 8", n);
                end
                n = 0;
            end
        end
    end

    initial begin
        int s;
        int wait_cnt;
        logic [1:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        tests = 0;
        fails = 0;
        cyc   = 0;
        rst_n = 1'b0;
        bus.ccx_req  = 1'b0;
        bus.ccx_rs_a = 4'd0;
        bus.ccx_rs_b = 4'd0;
        bus.ccx_sel  = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(3);

        txn(2'd0, 32'h8000_0001, 32'h0000_0004, "rol_dir");
        idle(2);
        txn(2'd1, 32'hF0F0_0001, 32'hDEAD_BEEF, "popc_dir");
        txn(2'd2, 32'h1122_3344, 32'h0000_0000, "rev8_dir");
        txn(2'd3, 32'h7FFF_FFFF, 32'h8000_0000, "maxu_dir");
        txn(2'd3, 32'h1234_5678, 32'h1234_5678, "maxu_eq");
        idle(3);

        // Abort after three chunks; nothing may come back.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            bus.ccx_req  = 1'b1;
            bus.ccx_rs_a = 4'($urandom);
            bus.ccx_rs_b = 4'($urandom);
            bus.ccx_sel  = 2'($urandom);
        end
        idle(20);
        txn(2'd0, 32'h0000_0001, 32'h0000_001F, "rol_after_abort");
        idle(2);

        // Reset in the 4th SEND cycle kills the transaction.
        send_chunks(2'd0, 32'hDEAD_BEEF, 32'h0000_0003, "rol_reset");
        s = cyc + 2;
        while (cyc < s + 3) begin
            @(posedge clk); #1;
            bus.ccx_req = 1'b0;
        end
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_now_resp", 32'(bus.ccx_resp), 32'd0);
        check("reset_now_res", 32'(bus.ccx_res), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(12);

        txn(2'd2, 32'hA1B2_C3D4, 32'h0000_0000, "rev8_b2b_0");
        txn(2'd2, 32'h0102_0304, 32'hFFFF_FFFF, "rev8_b2b_1");
        idle(2);

        for (int t = 0; t < 40; t++) begin
            sel = 2'($urandom);
            a   = $urandom;
            b   = ($urandom_range(3, 0) == 0) ? a : $urandom;
            txn(sel, a, b, "random");
            if ($urandom_range(1, 0) == 1) idle($urandom_range(5, 1));
        end

        idle(2);
        wait_cnt = 0;
        while (exp_q.size() != 0 && wait_cnt < 200) begin
            @(posedge clk);
            wait_cnt++;
        end
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
